burst_ram_arbiter: RTL

- Shares one burst RAM command port (Gowin PSRAM HS style: cmd, cmd_en, addr, 64-bit data, 4-beat bursts) between two cache requesters, m0 (instruction cache) and m1 (data cache).
- Arbitrates round-robin and holds the port for the owner until its whole burst completes.
- Enforces the minimum command interval globally, because neither cache knows about the other's commands.
- Sits between the two cache instances and the PSRAM IP.

---
 rtl/burst_ram_arbiter_if.sv | 24 ++
 rtl/burst_ram_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter_if.sv
// One requester channel of the burst RAM arbiter: a cache-side command,
// its write beats, and the read data returned to it.
interface burst_ram_arbiter_if #(
  parameter int ADDR_W = 21
) ();
  logic              req;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wr_data;
  logic              ack;
  logic [63:0]       rd_data;
  logic              rd_data_valid;
  logic              busy;

  modport master (
    output req, cmd, addr, wr_data,
    input  ack, rd_data, rd_data_valid, busy
  );

  modport slave (
    input  req, cmd, addr, wr_data,
    output ack, rd_data, rd_data_valid, busy
  );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one PSRAM-style burst command port between an
// instruction cache (m0) and a data cache (m1), with a global command interval.
module burst_ram_arbiter #(
  parameter int RAM_DEPTH_BITWIDTH     = 21,
  parameter int COMMAND_DELAY_INTERVAL = 13,
  parameter int BURST_BEATS            = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  burst_ram_arbiter_if.slave            m0,
  burst_ram_arbiter_if.slave            m1,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid
);

  localparam int              CNT_W      = (COMMAND_DELAY_INTERVAL > 0) ?
                                           $clog2(COMMAND_DELAY_INTERVAL + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(COMMAND_DELAY_INTERVAL);
  localparam logic [2:0]       LAST_BEAT  = 3'(BURST_BEATS);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        interval_cnt;
  logic [2:0]              beat_cnt;
  logic                    rr_ptr;       // side that wins a tie: 0 = m0, 1 = m1
  logic                    owner_valid;
  logic                    owner;
  logic                    m0_ack_q;
  logic                    m1_ack_q;

  logic                          any_req;
  logic                          win_m1;
  logic                          win_cmd;
  logic [RAM_DEPTH_BITWIDTH-1:0] win_addr;
  logic [63:0]                   win_wr_data;
  logic [63:0]                   own_wr_data;

  // NOTE: every signal assigned in always_comb gets a default first so no latch can be inferred.
  always_comb begin
    any_req     = m0.req | m1.req;
    win_m1      = m1.req & (~m0.req | rr_ptr);
    win_cmd     = win_m1 ? m1.cmd     : m0.cmd;
    win_addr    = win_m1 ? m1.addr    : m0.addr;
    win_wr_data = win_m1 ? m1.wr_data : m0.wr_data;
    own_wr_data = owner  ? m1.wr_data : m0.wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      interval_cnt <= '0;
      beat_cnt     <= '0;
      rr_ptr       <= 1'b0;
      owner_valid  <= 1'b0;
      owner        <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      br_cmd       <= 1'b0;
      br_cmd_en    <= 1'b0;
      br_addr      <= '0;
      br_wr_data   <= '0;
    end else begin
      br_cmd_en <= 1'b0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      if (interval_cnt != '0) interval_cnt <= interval_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (interval_cnt == '0 && any_req) begin
            interval_cnt <= CNT_RELOAD;
            br_cmd_en    <= 1'b1;
            br_cmd       <= win_cmd;
            br_addr      <= win_addr;
            br_wr_data   <= win_wr_data;
            m0_ack_q     <= ~win_m1;
            m1_ack_q     <= win_m1;
            owner_valid  <= 1'b1;
            owner        <= win_m1;
            rr_ptr       <= ~win_m1;
            // Beat 0 travels with the command, so a write starts counting at 1.
            beat_cnt     <= win_cmd ? 3'd1 : 3'd0;
            state        <= win_cmd ? WRITE : READ;
          end
        end

        WRITE: begin
          if (beat_cnt == LAST_BEAT) begin
            state       <= IDLE;
            owner_valid <= 1'b0;
          end else begin
            br_wr_data <= own_wr_data;
            beat_cnt   <= beat_cnt + 3'd1;
          end
        end

        READ: begin
          if (br_rd_data_valid) begin
            if (beat_cnt == LAST_BEAT - 3'd1) begin
              state       <= IDLE;
              owner_valid <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign br_data_mask = '0;

  assign m0.ack = m0_ack_q;
  assign m1.ack = m1_ack_q;

  assign m0.rd_data = br_rd_data;
  assign m1.rd_data = br_rd_data;

  // Read valid reaches only the owner of an active read; strays are dropped.
  assign m0.rd_data_valid = br_rd_data_valid & (state == READ) & ~owner;
  assign m1.rd_data_valid = br_rd_data_valid & (state == READ) &  owner;

  assign m0.busy = owner_valid &  owner;
  assign m1.busy = owner_valid & ~owner;

endmodule
